// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU write-back stage: opcode encoding, legal-op decode and
// default widths.
package alu_writeback_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int RF_AW_DEF    = 4;
    localparam int WB_DEPTH_DEF = 2;

    typedef enum logic [3:0] {
        ALUOP_ADD  = 4'b0000,
        ALUOP_AND  = 4'b0001,
        ALUOP_OR   = 4'b0010,
        ALUOP_ROR  = 4'b0011,
        ALUOP_NOT  = 4'b0100,
        ALUOP_XOR  = 4'b0101,
        ALUOP_ROL  = 4'b0110,
        ALUOP_SWAP = 4'b0111,
        ALUOP_SUB  = 4'b1000
    } aluop_e;

    // ROL has an encoding but is unsupported by this stage, so it decodes as illegal.
    function automatic logic is_legal_op(input logic [3:0] op);
        logic legal;
        case (op)
            ALUOP_ADD, ALUOP_SUB, ALUOP_AND, ALUOP_OR,
            ALUOP_XOR, ALUOP_NOT, ALUOP_ROR, ALUOP_SWAP: legal = 1'b1;
            default:                                     legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_writeback_if.sv
// Issue bus, registered ALU result bus and register-file write handshake of the write-back stage.
interface alu_writeback_if
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int RF_AW  = RF_AW_DEF
) ();

    logic              issue_valid;
    logic [3:0]        issue_op;
    logic [RF_AW-1:0]  issue_dst;
    logic              issue_wr_w;
    logic              issue_wr_f;
    logic              issue_upd_c;
    logic              issue_upd_z;
    logic              stall_o;

    logic              alu_cout;
    logic              aluz;
    logic [DATA_W-1:0] aluout;

    logic              rf_wvalid;
    logic [RF_AW-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              rf_wready;

    modport master (
        output issue_valid, issue_op, issue_dst, issue_wr_w, issue_wr_f, issue_upd_c, issue_upd_z,
        output alu_cout, aluz, aluout, rf_wready,
        input  stall_o, rf_wvalid, rf_waddr, rf_wdata
    );

    modport slave (
        input  issue_valid, issue_op, issue_dst, issue_wr_w, issue_wr_f, issue_upd_c, issue_upd_z,
        input  alu_cout, aluz, aluout, rf_wready,
        output stall_o, rf_wvalid, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/alu_writeback_wb_fifo.sv
// Small synchronous FIFO with occupancy count; a push into a full FIFO is accepted only
// when a pop happens in the same cycle.
module wb_fifo #(
    parameter int  DEPTH = 2,
    parameter int  WIDTH = 12,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // NOTE: storage is not reset; an entry is only visible through pop_data once count covers it.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_writeback.sv
// ALU write-back stage: aligns the issue tag with the one-cycle-late ALU result, retires it
// into W, the C/Z flags and a register-file write FIFO, and forwards carry to the ALU.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int RF_AW    = RF_AW_DEF,
    parameter int WB_DEPTH = WB_DEPTH_DEF
) (
    input  logic              clk3,
    input  logic              resetn,
    alu_writeback_if.slave    bus,
    output logic              status0,
    output logic [DATA_W-1:0] w_reg,
    output logic              status_c,
    output logic              status_z,
    output logic              illegal_op,
    output logic              drop_err
);

    localparam int CW = $clog2(WB_DEPTH + 1);

    typedef struct packed {
        logic             valid;
        logic [3:0]       op;
        logic [RF_AW-1:0] dst;
        logic             wr_w;
        logic             wr_f;
        logic             upd_c;
        logic             upd_z;
    } tag_t;

    tag_t                      tag;
    logic                      tag_legal;
    logic                      retire;
    logic                      issue_accept;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [CW-1:0]             fifo_count;
    logic [RF_AW+DATA_W-1:0]   fifo_head;

    assign tag_legal    = is_legal_op(tag.op);
    assign retire       = tag.valid && tag_legal;
    assign issue_accept = bus.issue_valid && !bus.stall_o;

    // Reserve a slot for the op in flight so an accepted op always finds room at retire.
    assign bus.stall_o = fifo_full ||
                         (tag.valid && tag.wr_f && (fifo_count == CW'(WB_DEPTH - 1)));

    // Forward the retiring carry so a back-to-back ROR sees it before status_c updates.
    assign status0 = (retire && tag.upd_c) ? bus.alu_cout : status_c;

    always_ff @(posedge clk3 or negedge resetn) begin
        if (!resetn) begin
            tag <= '0;
        end else begin
            tag.valid <= issue_accept;
            if (issue_accept) begin
                tag.op    <= bus.issue_op;
                tag.dst   <= bus.issue_dst;
                tag.wr_w  <= bus.issue_wr_w;
                tag.wr_f  <= bus.issue_wr_f;
                tag.upd_c <= bus.issue_upd_c;
                tag.upd_z <= bus.issue_upd_z;
            end
        end
    end

    always_ff @(posedge clk3 or negedge resetn) begin
        if (!resetn) begin
            w_reg      <= '0;
            status_c   <= 1'b0;
            status_z   <= 1'b0;
            illegal_op <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            illegal_op <= tag.valid && !tag_legal;
            if (bus.issue_valid && bus.stall_o) drop_err <= 1'b1;
            if (retire) begin
                if (tag.wr_w)  w_reg    <= bus.aluout;
                if (tag.upd_c) status_c <= bus.alu_cout;
                if (tag.upd_z) status_z <= bus.aluz;
            end
        end
    end

    wb_fifo #(
        .DEPTH (WB_DEPTH),
        .WIDTH (RF_AW + DATA_W)
    ) u_wb_fifo (
        .clk       (clk3),
        .rst_n     (resetn),
        .push      (retire && tag.wr_f),
        .push_data ({tag.dst, bus.aluout}),
        .pop       (bus.rf_wvalid && bus.rf_wready),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.rf_wvalid = !fifo_empty;
    assign bus.rf_waddr  = fifo_head[RF_AW+DATA_W-1:DATA_W];
    assign bus.rf_wdata  = fifo_head[DATA_W-1:0];

endmodule
